// File: rtl/cva6_rvfi_dii_pkg.sv
// Shared types for the RVFI-DII instruction injection path.
package cva6_rvfi_dii_pkg;

  typedef enum logic {
    DII_END  = 1'b0,
    DII_INSN = 1'b1
  } dii_cmd_e;

  typedef struct packed {
    dii_cmd_e    cmd;
    logic [7:0]  dii_time;
    logic [31:0] insn;
  } dii_packet_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } inj_state_e;

endpackage

// File: rtl/cva6_rvfi_dii_injector.sv
// Replay ring feeding injected instructions to the frontend,
// rewinding on flush and reporting end-of-trace on full retirement.
module cva6_rvfi_dii_injector #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INSN_W = 32,
  parameter int unsigned SEQ_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dii_valid_i,
  output logic              dii_ready_o,
  input  logic              dii_cmd_i,
  input  logic [INSN_W-1:0] dii_insn_i,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  output logic [INSN_W-1:0] fetch_insn_o,
  output logic [SEQ_W-1:0]  fetch_seq_o,
  input  logic              commit_i,
  input  logic              flush_i,
  output logic              trace_end_o,
  output logic              busy_o
);

  import cva6_rvfi_dii_pkg::*;

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef logic [PW-1:0] ptr_t;

  inj_state_e       state_q, state_d;
  ptr_t             wr_p_q, wr_p_d;
  ptr_t             rd_p_q, rd_p_d;
  ptr_t             cm_p_q, cm_p_d;
  logic [SEQ_W-1:0] base_q, base_d;
  logic             tend_q, tend_d;

  logic [INSN_W-1:0] ring_q [DEPTH];

  logic full;
  logic accept;
  logic wr_en;
  logic end_acc;
  logic fire;
  logic empty;
  ptr_t occ;

  always_comb begin
    full    = (wr_p_q - cm_p_q) == ptr_t'(DEPTH);
    empty   = rd_p_q == wr_p_q;
    dii_ready_o = !rst_i && !full && (state_q != ST_DRAIN);
    accept  = dii_valid_i && dii_ready_o;
    wr_en   = accept && (dii_cmd_i == DII_INSN);
    end_acc = accept && (dii_cmd_i == DII_END);
    fetch_valid_o = !rst_i && !empty && !flush_i;
    fire    = fetch_valid_o && fetch_ready_i;
    occ     = rd_p_q - cm_p_q;
  end

  always_comb begin
    state_d = state_q;
    tend_d  = 1'b0;
    wr_p_d  = wr_p_q + ptr_t'(wr_en);
    cm_p_d  = cm_p_q + ptr_t'(commit_i);
    base_d  = base_q + SEQ_W'(commit_i);
    rd_p_d  = rd_p_q + ptr_t'(fire);
    // Flush rewinds past any same-cycle commit, so no fetch advance.
    if (flush_i) begin
      rd_p_d = cm_p_d;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          state_d = ST_RUN;
        end else if (end_acc) begin
          tend_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (end_acc) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cm_p_d == wr_p_q) begin
          state_d = ST_IDLE;
          tend_d  = 1'b1;
          wr_p_d  = '0;
          rd_p_d  = '0;
          cm_p_d  = '0;
          base_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wr_p_q  <= '0;
      rd_p_q  <= '0;
      cm_p_q  <= '0;
      base_q  <= '0;
      tend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_p_q  <= wr_p_d;
      rd_p_q  <= rd_p_d;
      cm_p_q  <= cm_p_d;
      base_q  <= base_d;
      tend_q  <= tend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      ring_q[wr_p_q[IW-1:0]] <= dii_insn_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && commit_i) begin
      assert (cm_p_q != rd_p_q)
        else $error("commit with no fetched instruction");
    end
  end

  always_comb begin
    fetch_insn_o = '0;
    fetch_seq_o  = '0;
    if (!rst_i && !empty) begin
      fetch_insn_o = ring_q[rd_p_q[IW-1:0]];
      fetch_seq_o  = base_q + SEQ_W'(occ);
    end
    trace_end_o = tend_q;
    busy_o      = !rst_i && (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_cva6_rvfi_dii_injector.sv
// Directed bench for the RVFI-DII injector replay ring.
module tb_cva6_rvfi_dii_injector;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dii_valid_i;
  logic        dii_ready_o;
  logic        dii_cmd_i;
  logic [31:0] dii_insn_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_insn_o;
  logic [15:0] fetch_seq_o;
  logic        commit_i;
  logic        flush_i;
  logic        trace_end_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;
  int te_cnt = 0;
  int te_ref;

  cva6_rvfi_dii_injector dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .dii_valid_i   (dii_valid_i),
    .dii_ready_o   (dii_ready_o),
    .dii_cmd_i     (dii_cmd_i),
    .dii_insn_i    (dii_insn_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_insn_o  (fetch_insn_o),
    .fetch_seq_o   (fetch_seq_o),
    .commit_i      (commit_i),
    .flush_i       (flush_i),
    .trace_end_o   (trace_end_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (trace_end_o === 1'b1) te_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    dii_valid_i   = 1'b0;
    dii_cmd_i     = 1'b0;
    dii_insn_i    = '0;
    fetch_ready_i = 1'b0;
    commit_i      = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic push(input logic cmd, input logic [31:0] w);
    dii_valid_i = 1'b1;
    dii_cmd_i   = cmd;
    dii_insn_i  = w;
  endtask

  logic [31:0] bw [3];
  logic [31:0] fw [5];

  initial begin
    bw[0] = 32'h0000_0013;
    bw[1] = 32'h0010_0093;
    bw[2] = 32'h0020_8113;
    for (int i = 0; i < 5; i++) fw[i] = 32'hB000_0000 + i;

    // reset / idle
    idle_in();
    rst_i = 1'b1;
    repeat (3) tick();
    chk("rst_ready", dii_ready_o, 0);
    chk("rst_fvalid", fetch_valid_o, 0);
    rst_i = 1'b0;
    #1;
    chk("idle_ready", dii_ready_o, 1);
    chk("idle_fvalid", fetch_valid_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_seq", fetch_seq_o, 0);
    repeat (2) tick();
    chk("idle_tend", trace_end_o, 0);
    chk("idle_tecnt", te_cnt, 0);

    // basic stream, one-cycle write-to-fetch
    do_reset();
    fetch_ready_i = 1'b1;
    push(1'b1, bw[0]);
    #1;
    chk("bs_nofetch0", fetch_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) push(1'b1, bw[i+1]);
      else dii_valid_i = 1'b0;
      #1;
      chk("bs_valid", fetch_valid_o, 1);
      chk("bs_insn", fetch_insn_o, bw[i]);
      chk("bs_seq", fetch_seq_o, i);
    end
    tick();
    chk("bs_empty", fetch_valid_o, 0);
    chk("bs_busy", busy_o, 1);

    // full backpressure
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(1'b1, 32'hA0 + i);
      #1;
      chk("fl_ready_pre", dii_ready_o, 1);
      tick();
    end
    dii_valid_i = 1'b0;
    #1;
    chk("fl_full", dii_ready_o, 0);
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fl_fvalid", fetch_valid_o, 1);
      chk("fl_insn", fetch_insn_o, 32'hA0 + i);
      chk("fl_seq", fetch_seq_o, i);
      tick();
    end
    fetch_ready_i = 1'b0;
    chk("fl_drained", fetch_valid_o, 0);
    chk("fl_still_full", dii_ready_o, 0);
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    #1;
    chk("fl_freed", dii_ready_o, 1);

    // flush replay with same-cycle commit
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(1'b1, fw[i]);
      tick();
    end
    dii_valid_i = 1'b0;
    fetch_ready_i = 1'b1;
    repeat (4) tick();
    fetch_ready_i = 1'b0;
    chk("fr_seq4", fetch_seq_o, 4);
    commit_i = 1'b1;
    repeat (2) tick();
    flush_i = 1'b1;
    #1;
    chk("fr_flush_gate", fetch_valid_o, 0);
    tick();
    commit_i = 1'b0;
    flush_i  = 1'b0;
    #1;
    chk("fr_valid", fetch_valid_o, 1);
    chk("fr_seq", fetch_seq_o, 3);
    chk("fr_insn", fetch_insn_o, fw[3]);
    fetch_ready_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
    chk("fr_seq_next", fetch_seq_o, 4);
    chk("fr_insn_next", fetch_insn_o, fw[4]);

    // end-of-trace with retirement
    do_reset();
    te_ref = te_cnt;
    fetch_ready_i = 1'b1;
    push(1'b1, 32'h1111_0013);
    tick();
    push(1'b1, 32'h2222_0013);
    tick();
    push(1'b0, 32'h0);
    tick();
    dii_valid_i = 1'b0;
    fetch_ready_i = 1'b0;
    #1;
    chk("et_drain_ready", dii_ready_o, 0);
    chk("et_drain_busy", busy_o, 1);
    commit_i = 1'b1;
    tick();
    chk("et_no_early", trace_end_o, 0);
    tick();
    commit_i = 1'b0;
    chk("et_pulse", trace_end_o, 1);
    chk("et_idle", busy_o, 0);
    tick();
    chk("et_pulse_end", trace_end_o, 0);
    chk("et_tecnt", te_cnt - te_ref, 1);
    push(1'b1, 32'h3333_0013);
    tick();
    dii_valid_i = 1'b0;
    #1;
    chk("et_restart_v", fetch_valid_o, 1);
    chk("et_restart_seq", fetch_seq_o, 0);

    // empty trace from IDLE
    do_reset();
    push(1'b0, 32'h0);
    tick();
    dii_valid_i = 1'b0;
    chk("ie_pulse", trace_end_o, 1);
    chk("ie_busy", busy_o, 0);
    tick();
    chk("ie_pulse_end", trace_end_o, 0);

    // reset mid-DRAIN
    do_reset();
    te_ref = te_cnt;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 32'hC0 + i);
      tick();
    end
    push(1'b0, 32'h0);
    tick();
    dii_valid_i = 1'b0;
    #1;
    chk("rd_busy", busy_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rd_fvalid", fetch_valid_o, 0);
    chk("rd_ready", dii_ready_o, 1);
    chk("rd_busy0", busy_o, 0);
    tick();
    chk("rd_no_tend", trace_end_o, 0);
    chk("rd_tecnt", te_cnt - te_ref, 0);
    push(1'b1, 32'hD00D_0013);
    tick();
    dii_valid_i = 1'b0;
    #1;
    chk("rd_new_v", fetch_valid_o, 1);
    chk("rd_new_insn", fetch_insn_o, 32'hD00D_0013);
    chk("rd_new_seq", fetch_seq_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
